rr_tree_arb_lock: RTL

Parametrised round-robin arbiter: N requesters, registered one-hot grant, optional per-requester burst lock with bounded hold. Successor of the fixed 8-way round-robin tree arbiter. Sits in front of shared resources such as bus ports and memory banks that need multi-cycle ownership. A requester that asserts `lock` keeps the grant across a burst; everyone else rotates fairly.

---
 rtl/rr_tree_arb_lock_if.sv | 36 +++
 rtl/rr_tree_arb_lock.sv | 112 +++++++++++
 2 files changed

// File: rtl/rr_tree_arb_lock_if.sv
// Arbiter request/grant bundle.
// Purpose: groups the request, lock and grant signals of rr_tree_arb_lock.
// Signals:
//   req       [N-1:0]   request vector, one bit per requester
//   lock      [N-1:0]   holder asks to keep its grant
//   gnt       [N-1:0]   registered one-hot grant, or zero
//   gnt_valid           |gnt, registered
//   gnt_id    [IDW-1:0] index of the set gnt bit, 0 when idle
// Modports: master = requester side, slave = arbiter side.
interface rr_tree_arb_lock_if #(
    parameter int unsigned N = 8
);
    localparam int unsigned IDW = $clog2(N);

    logic [N-1:0]   req;
    logic [N-1:0]   lock;
    logic [N-1:0]   gnt;
    logic           gnt_valid;
    logic [IDW-1:0] gnt_id;

    modport master (
        output req,
        output lock,
        input  gnt,
        input  gnt_valid,
        input  gnt_id
    );

    modport slave (
        input  req,
        input  lock,
        output gnt,
        output gnt_valid,
        output gnt_id
    );
endinterface

// File: rtl/rr_tree_arb_lock.sv
// rr_tree_arb_lock: N-way round-robin arbiter with registered one-hot grant
// and per-requester burst lock.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - rr_tree_arb_lock_if.slave (req, lock in; gnt, gnt_valid, gnt_id out)
// Parameters:
//   N        - requester count, power of two, 2..64
//   MAX_HOLD - longest locked burst in cycles, 1..255
// Optional feature: define RR_ARB_MAXHOLD_EN to force-release a locked holder
// after MAX_HOLD consecutive grant cycles. Without it lock holds indefinitely.
module rr_tree_arb_lock #(
    parameter int unsigned N        = 8,
    parameter int unsigned MAX_HOLD = 4
) (
    input logic             clk,
    input logic             rst,
    rr_tree_arb_lock_if.slave bus
);
    localparam int unsigned IDW = $clog2(N);

    // Elaboration-time parameter sanity.
    if (N < 2 || N > 64 || (N & (N - 1)) != 0) begin : g_bad_n
        $error("rr_tree_arb_lock: N must be a power of two in 2..64");
    end
    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
        $error("rr_tree_arb_lock: MAX_HOLD must be in 1..255");
    end

    logic [N-1:0]   gnt_q,       gnt_d;
    logic           gnt_valid_q, gnt_valid_d;
    logic [IDW-1:0] gnt_id_q,    gnt_id_d;
    logic [IDW-1:0] ptr_q,       ptr_d;
    logic [7:0]     hold_q,      hold_d;

    logic           keep_c;
    logic           hold_ok_c;
    logic           win_found_c;
    logic [IDW-1:0] win_idx_c;

`ifdef RR_ARB_MAXHOLD_EN
    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);
    assign hold_ok_c = (hold_q < HOLD_LIMIT);
`else
    assign hold_ok_c = 1'b1;
`endif

    // Current holder keeps the grant while it still requests and locks.
    assign keep_c = gnt_valid_q && bus.req[gnt_id_q] && bus.lock[gnt_id_q] && hold_ok_c;

    // First set request at or after ptr; IDW-bit add wraps modulo N.
    always_comb begin
        logic [IDW-1:0] cand;
        win_found_c = 1'b0;
        win_idx_c   = '0;
        cand        = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = ptr_q + IDW'(k);
            if (!win_found_c && bus.req[cand]) begin
                win_found_c = 1'b1;
                win_idx_c   = cand;
            end
        end
    end

    // Next-state: keep the holder, grant a new winner, or go idle.
    always_comb begin
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
        gnt_id_d    = gnt_id_q;
        ptr_d       = ptr_q;
        hold_d      = hold_q;
        if (keep_c) begin
            // Saturates so an unlimited lock never wraps the counter.
            hold_d = (hold_q == 8'hFF) ? hold_q : hold_q + 8'd1;
        end else if (win_found_c) begin
            gnt_d            = '0;
            gnt_d[win_idx_c] = 1'b1;
            gnt_valid_d      = 1'b1;
            gnt_id_d         = win_idx_c;
            // Winner becomes lowest priority for the next arbitration.
            ptr_d            = win_idx_c + IDW'(1);
            hold_d           = 8'd1;
        end else begin
            gnt_d       = '0;
            gnt_valid_d = 1'b0;
            gnt_id_d    = '0;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
            ptr_q       <= '0;
            hold_q      <= '0;
        end else begin
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_id_q    <= gnt_id_d;
            ptr_q       <= ptr_d;
            hold_q      <= hold_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.gnt_id    = gnt_id_q;

endmodule
